// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder slice.
//   state_t  : sequencing FSM states (IDLE, RUN, DONE)
//   req_id_t : requester identifier (two requesters -> 1 bit)
//   DEF_W    : default operand/sum width
//   maj3     : carry function of a full adder
package serial_add_pkg;

  localparam int unsigned DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic req_id_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// Bit-serial full adder: one sum bit per enabled cycle, carry kept in a flop.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   clr        : clear the carry flop (wins over en)
//   en         : advance one bit (update the carry flop)
//   a, b       : current operand bits
//   s          : combinational sum bit of a, b and the stored carry
//   carry      : stored carry (carry out of the last processed bit)
module serial_fa_bit
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);

  assign s = a ^ b ^ carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= maj3(a, b, carry);
    end
  end

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin front end for one shared bit-serial adder.
// An accepted operand pair is added LSB-first over W cycles; the W-bit sum,
// carry-out and owner ID are then offered on a valid/ready response channel.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   req0_valid/ready, req0_a/b     : requester 0 operand handshake
//   req1_valid/ready, req1_a/b     : requester 1 operand handshake
//   resp_valid/ready               : result handshake
//   resp_id, resp_sum, resp_cout   : result owner, (A+B) mod 2^W, carry out
//   busy                           : high while an operation is in RUN or DONE
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_sum,
  output logic         resp_cout,
  output logic         busy
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

  state_t        state;
  req_id_t       last;
  req_id_t       grant;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_r;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          run_en;
  logic          last_bit;
  logic          fa_s;
  logic          fa_carry;

  // Round-robin: a lone requester always wins; on a tie the one not served
  // last wins. Dropping valid while not granted leaves 'last' untouched.
  always_comb begin
    grant = ~last;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && (grant == 1'b0) && req0_valid;
  assign req1_ready = (state == IDLE) && (grant == 1'b1) && req1_valid;
  assign accept     = req0_ready | req1_ready;
  assign run_en     = (state == RUN);
  assign last_bit   = (cnt == CW'(W - 1));

  // The carry flop lives in the adder slice; it is cleared on accept so that
  // after the final RUN cycle it holds the carry out of bit W-1.
  serial_fa_bit u_fa (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (run_en),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .s     (fa_s),
    .carry (fa_carry)
  );

  assign resp_sum  = sum_r;
  assign resp_cout = fa_carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_r      <= '0;
      cnt        <= '0;
      resp_id    <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh    <= grant ? req1_a : req0_a;
            b_sh    <= grant ? req1_b : req0_b;
            cnt     <= '0;
            resp_id <= grant;
            last    <= grant;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_r <= {fa_s, sum_r[W-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arb.sv
module tb_serial_add_arb;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_sum;
  logic         resp_cout;
  logic         busy;

  int n_cmp;
  int n_bad;
  int cyc;

  serial_add_arb #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where a ready is seen.
  task automatic wait_ready(output int who);
    who = -1;
    for (int k = 0; k < 30; k++) begin
      if (req0_ready) begin who = 0; return; end
      if (req1_ready) begin who = 1; return; end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at the negedge before the accepting edge; returns the number of
  // edges after the accept until resp_valid is seen, or -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) begin lat = k - 1; return; end
    end
  endtask

  initial begin
    int who;
    int lat;
    int acc_cyc;
    int prev_cyc;
    logic [7:0] exp_sum;
    logic       exp_cout;

    n_cmp = 0;
    n_bad = 0;
    prev_cyc = 0;

    // Reset with both requesters valid
    reset      = 1'b0;
    req0_valid = 1'b1;
    req0_a     = 8'h5A;
    req0_b     = 8'h33;
    req1_valid = 1'b1;
    req1_a     = 8'hFF;
    req1_b     = 8'h01;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_sum",   32'(resp_sum),   32'h00);
    chk("rst_resp_cout",  32'(resp_cout),  32'd0);
    chk("rst_resp_id",    32'(resp_id),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    reset = 1'b1;
    #1;
    chk("first_ready0", 32'(req0_ready), 32'd1);
    chk("first_ready1", 32'(req1_ready), 32'd0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      wait_ready(who);
      acc_cyc = cyc;
      chk("grant_id", 32'(who), 32'(i % 2));
      chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (i > 0) chk("period", 32'(acc_cyc - prev_cyc), 32'd10);
      prev_cyc = acc_cyc;
      if (i == 3) resp_ready = 1'b0;
      wait_resp(lat);
      chk("latency", 32'(lat), 32'd8);
      exp_sum  = (i % 2 == 0) ? 8'h8D : 8'h00;
      exp_cout = (i % 2 == 0) ? 1'b0 : 1'b1;
      chk("sum",  32'(resp_sum),  32'(exp_sum));
      chk("cout", 32'(resp_cout), 32'(exp_cout));
      chk("id",   32'(resp_id),   32'(i % 2));
      chk("busy_done", 32'(busy), 32'd1);
    end

    // Response back-pressure: result held stable, no requester accepted
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid",  32'(resp_valid), 32'd1);
      chk("hold_sum",    32'(resp_sum),   32'h00);
      chk("hold_cout",   32'(resp_cout),  32'd1);
      chk("hold_id",     32'(resp_id),    32'd1);
      chk("hold_ready",  32'({req0_ready, req1_ready}), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_busy",  32'(busy),       32'd0);
    chk("post_hs_sum",   32'(resp_sum),   32'h00);
    chk("post_hs_cout",  32'(resp_cout),  32'd1);
    chk("post_hs_rdy0",  32'(req0_ready), 32'd1);
    chk("post_hs_rdy1",  32'(req1_ready), 32'd0);

    // Reset mid-RUN: 06+03 partially added (sum bits and carry non-zero)
    req1_valid = 1'b0;
    req0_a     = 8'h06;
    req0_b     = 8'h03;
    @(posedge clk);           // accept
    repeat (3) @(posedge clk); // cnt = 3
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_sum",   32'(resp_sum),   32'h00);
    chk("mid_rst_cout",  32'(resp_cout),  32'd0);
    chk("mid_rst_id",    32'(resp_id),    32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    req0_a = 8'h10;
    req0_b = 8'h20;
    @(negedge clk);
    reset = 1'b1;
    #1;
    wait_ready(who);
    chk("fresh_grant", 32'(who), 32'd0);
    wait_resp(lat);
    chk("fresh_latency", 32'(lat), 32'd8);
    chk("fresh_sum",  32'(resp_sum),  32'h30);
    chk("fresh_cout", 32'(resp_cout), 32'd0);
    chk("fresh_id",   32'(resp_id),   32'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("end_valid", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
